// File: rtl/voice_alloc.sv
// voice_alloc: assigns note-on/note-off events to a small pool of envelope voices.
// Each accepted event scans every voice (one per cycle), then commits in one cycle.
//
// state  | meaning
// IDLE   | ev_ready high, waiting for ev_valid
// SCAN   | sampling voice_active[idx_q], idx_q = 0..NUM_VOICES-1
// COMMIT | apply the allocation decision, pulse ev_done
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    input  logic [7:0]                      ev_a,
    input  logic [7:0]                      ev_r,
    input  logic [NUM_VOICES-1:0]           voice_active,
    output logic [NUM_VOICES-1:0]           gate,
    output logic [NUM_VOICES*NOTE_BITS-1:0] note_out,
    output logic [NUM_VOICES*8-1:0]         a_out,
    output logic [NUM_VOICES*8-1:0]         r_out,
    output logic                            ev_done,
    output logic [$clog2(NUM_VOICES)-1:0]   ev_voice,
    output logic                            ev_hit,
    output logic                            steal
);
    localparam int VW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [VW-1:0]          idx_q, idx_d;
    logic                   on_q, on_d;
    logic [NOTE_BITS-1:0]   enote_q, enote_d;
    logic [7:0]             ea_q, ea_d, er_q, er_d;
    logic [NUM_VOICES-1:0]  inactive_q, inactive_d;
    logic [NUM_VOICES-1:0]  gate_q, gate_d;
    logic [NOTE_BITS-1:0]   vnote_q [NUM_VOICES];
    logic [NOTE_BITS-1:0]   vnote_d [NUM_VOICES];
    logic [7:0]             va_q [NUM_VOICES];
    logic [7:0]             va_d [NUM_VOICES];
    logic [7:0]             vr_q [NUM_VOICES];
    logic [7:0]             vr_d [NUM_VOICES];
    logic [VW-1:0]          age_q [NUM_VOICES];
    logic [VW-1:0]          age_d [NUM_VOICES];
    logic                   done_q, done_d, hit_q, hit_d, steal_q, steal_d;
    logic [VW-1:0]          evv_q, evv_d;

    // decision helpers
    logic                   match_any, free_any, ung_any;
    logic [VW-1:0]          match_idx, free_idx, ung_idx, ung_age, old_idx, chosen, chosen_age;
    logic [NUM_VOICES-1:0]  off_mask;

    // register all state; reset restores age[i] = i so ranks start as a permutation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            on_q       <= 1'b0;
            enote_q    <= '0;
            ea_q       <= '0;
            er_q       <= '0;
            inactive_q <= '0;
            gate_q     <= '0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            steal_q    <= 1'b0;
            evv_q      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vnote_q[i] <= '0;
                va_q[i]    <= '0;
                vr_q[i]    <= '0;
                age_q[i]   <= VW'(i);
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            on_q       <= on_d;
            enote_q    <= enote_d;
            ea_q       <= ea_d;
            er_q       <= er_d;
            inactive_q <= inactive_d;
            gate_q     <= gate_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            steal_q    <= steal_d;
            evv_q      <= evv_d;
            vnote_q    <= vnote_d;
            va_q       <= va_d;
            vr_q       <= vr_d;
            age_q      <= age_d;
        end
    end

    // priority search over the voice pool (lowest index wins on ties)
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        off_mask  = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        ung_any   = 1'b0;
        ung_idx   = '0;
        ung_age   = '0;
        old_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && vnote_q[i] == enote_q) begin
                match_any   = 1'b1;
                match_idx   = VW'(i);
                off_mask[i] = 1'b1;
            end
            if (!gate_q[i] && inactive_q[i]) begin
                free_any = 1'b1;
                free_idx = VW'(i);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!gate_q[i] && (!ung_any || age_q[i] > ung_age)) begin
                ung_any = 1'b1;
                ung_idx = VW'(i);
                ung_age = age_q[i];
            end
            if (age_q[i] == VW'(NUM_VOICES - 1)) old_idx = VW'(i);
        end
        if (match_any)     chosen = match_idx;
        else if (free_any) chosen = free_idx;
        else if (ung_any)  chosen = ung_idx;
        else               chosen = old_idx;
        chosen_age = age_q[chosen];
    end

    // next-state: accept in IDLE, walk the voices in SCAN, apply the decision in COMMIT
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        on_d       = on_q;
        enote_d    = enote_q;
        ea_d       = ea_q;
        er_d       = er_q;
        inactive_d = inactive_q;
        gate_d     = gate_q;
        vnote_d    = vnote_q;
        va_d       = va_q;
        vr_d       = vr_q;
        age_d      = age_q;
        done_d     = 1'b0;
        steal_d    = 1'b0;
        hit_d      = hit_q;
        evv_d      = evv_q;
        case (state_q)
            IDLE: begin
                if (ev_valid) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    on_d    = ev_on;
                    enote_d = ev_note;
                    ea_d    = ev_a;
                    er_d    = ev_r;
                end
            end
            SCAN: begin
                inactive_d[idx_q] = ~voice_active[idx_q];
                if (idx_q == VW'(NUM_VOICES - 1)) state_d = COMMIT;
                else                              idx_d   = idx_q + VW'(1);
            end
            COMMIT: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (on_q) begin
                    hit_d       = match_any;
                    steal_d     = !match_any && !free_any && !ung_any;
                    evv_d       = chosen;
                    va_d[chosen] = ea_q;
                    vr_d[chosen] = er_q;
                    if (!match_any) begin
                        gate_d[chosen]  = 1'b1;
                        vnote_d[chosen] = enote_q;
                    end
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (VW'(i) == chosen)          age_d[i] = '0;
                        else if (age_q[i] < chosen_age) age_d[i] = age_q[i] + VW'(1);
                    end
                end else begin
                    gate_d = gate_q & ~off_mask;
                    hit_d  = match_any;
                    evv_d  = match_any ? match_idx : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // pack per-voice registers onto the flat output buses
    always_comb begin
        note_out = '0;
        a_out    = '0;
        r_out    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            note_out[i*NOTE_BITS +: NOTE_BITS] = vnote_q[i];
            a_out[i*8 +: 8]                    = va_q[i];
            r_out[i*8 +: 8]                    = vr_q[i];
        end
    end

    assign ev_ready = (state_q == IDLE);
    assign gate     = gate_q;
    assign ev_done  = done_q;
    assign ev_voice = evv_q;
    assign ev_hit   = hit_q;
    assign steal    = steal_q;
endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (4 voices, 7-bit notes) with a scoreboard.
module tb_voice_alloc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_valid = 1'b0, ev_on = 1'b0;
    logic [6:0]  ev_note = '0;
    logic [7:0]  ev_a = '0, ev_r = '0;
    logic [3:0]  voice_active = '0;
    logic        ev_ready, ev_done, ev_hit, steal;
    logic [3:0]  gate;
    logic [27:0] note_out;
    logic [31:0] a_out, r_out;
    logic [1:0]  ev_voice;

    voice_alloc #(.NUM_VOICES(4), .NOTE_BITS(7)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .ev_a(ev_a), .ev_r(ev_r),
        .voice_active(voice_active), .gate(gate), .note_out(note_out),
        .a_out(a_out), .r_out(r_out), .ev_done(ev_done), .ev_voice(ev_voice),
        .ev_hit(ev_hit), .steal(steal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  gate;
        logic [27:0] note;
        logic [31:0] a;
        logic [31:0] r;
        logic [1:0]  voice;
        logic        hit;
        logic        steal;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0, n_miss = 0;
    logic [6:0] m_note [4];
    logic [7:0] m_a [4];
    logic [7:0] m_r [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_note[i] = '0; m_a[i] = '0; m_r[i] = '0;
        end
    endtask

    // monitor: every ev_done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (steal && !ev_done) begin
            n_vec++; n_miss++;
            $display("FAIL steal_pulse: steal=1 while ev_done=0");
        end
        if (ev_done) begin
            if (sb.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_done: ev_done=1 with no event pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ev_voice", 64'(ev_voice), 64'(e.voice));
                check("ev_hit",   64'(ev_hit),   64'(e.hit));
                check("steal",    64'(steal),    64'(e.steal));
                check("gate",     64'(gate),     64'(e.gate));
                check("note_out", 64'(note_out), 64'(e.note));
                check("a_out",    64'(a_out),    64'(e.a));
                check("r_out",    64'(r_out),    64'(e.r));
            end
        end
    end

    // issue one event with hand-computed outcome; checks the N+1 edge latency too
    task automatic send(input logic on, input logic [6:0] note, input logic [7:0] a,
                        input logic [7:0] r, input logic [3:0] act,
                        input logic [1:0] xv, input logic xh, input logic xs,
                        input logic [3:0] xg);
        exp_t e;
        int   k;
        if (on) begin
            m_note[xv] = note; m_a[xv] = a; m_r[xv] = r;
        end
        e.gate = xg; e.voice = xv; e.hit = xh; e.steal = xs;
        for (int i = 0; i < 4; i++) begin
            e.note[i*7 +: 7] = m_note[i];
            e.a[i*8 +: 8]    = m_a[i];
            e.r[i*8 +: 8]    = m_r[i];
        end
        sb.push_back(e);
        @(negedge clk);
        ev_valid = 1'b1; ev_on = on; ev_note = note; ev_a = a; ev_r = r; voice_active = act;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        k = 0;
        while (k < 12) begin
            @(posedge clk);
            #1 k++;
            if (ev_done) break;
        end
        check("latency", 64'(k), 64'd5);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        #12 rst = 1'b0;
        @(negedge clk);
        check("rst_ready",  64'(ev_ready), 64'd1);
        check("rst_gate",   64'(gate),     64'd0);
        check("rst_note",   64'(note_out), 64'd0);
        check("rst_a",      64'(a_out),    64'd0);
        check("rst_done",   64'(ev_done),  64'd0);
        check("rst_voice",  64'(ev_voice), 64'd0);

        // fresh allocation, then fill every voice and steal the oldest
        send(1, 60, 10, 20, 4'b0000, 0, 0, 0, 4'b0001);
        send(1, 62, 11, 21, 4'b0001, 1, 0, 0, 4'b0011);
        send(1, 64, 12, 22, 4'b0011, 2, 0, 0, 4'b0111);
        send(1, 65, 13, 23, 4'b0111, 3, 0, 0, 4'b1111);
        send(1, 67, 14, 24, 4'b1111, 0, 0, 1, 4'b1111);
        // release voice 1, then the only ungated voice is reused without stealing
        send(0, 62, 0, 0, 4'b1111, 1, 1, 0, 4'b1101);
        send(1, 70, 15, 25, 4'b1111, 1, 0, 0, 4'b1111);
        // ages now 1,0,3,2 -> voice 2 is the oldest and gets stolen
        send(1, 72, 16, 26, 4'b1111, 2, 0, 1, 4'b1111);
        // note-off with no match
        send(0, 50, 0, 0, 4'b1111, 0, 0, 0, 4'b1111);

        // reset in the middle of a scan aborts the event
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd80; voice_active = 4'b0000;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
        #1;
        check("abort_gate", 64'(gate),     64'd0);
        check("abort_note", 64'(note_out), 64'd0);
        check("abort_r",    64'(r_out),    64'd0);
        check("abort_done", 64'(ev_done),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(ev_ready), 64'd1);
        repeat (8) @(negedge clk);
        check("abort_quiet", 64'(sb.size()), 64'd0);

        // retrigger of a gated voice only refreshes its rates
        do_reset();
        send(1, 60, 1, 2, 4'b0000, 0, 0, 0, 4'b0001);
        send(1, 62, 3, 4, 4'b0001, 1, 0, 0, 4'b0011);
        send(1, 64, 5, 6, 4'b0011, 2, 0, 0, 4'b0111);
        send(1, 64, 99, 7, 4'b0111, 2, 1, 0, 4'b0111);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
